// File: rtl/ram_access_ctrl_if.sv
// MEM-stage request/response bundle for the data RAM port.
// The MEM stage is master; ram_access_ctrl is slave.
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;

  modport master (
    output req_op, req_addr, req_wdata,
    input  stall, rdata, rdata_valid
  );

  modport slave (
    input  req_op, req_addr, req_wdata,
    output stall, rdata, rdata_valid
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Async SRAM access sequencer for the MEM stage (IDLE/ACCESS/RECOVER).
// Optional one-entry last-read cache: define RAM_LAST_READ_CACHE_EN.
module ram_access_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_access_ctrl_if.slave  mem,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic              wr_q;
  logic              dq_oe;
  logic              rv_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic is_rd;
  logic is_wr;
  logic hit;
  logic go;
  logic done;

  assign is_rd = mem.req_op == 2'b01;
  assign is_wr = mem.req_op == 2'b10;
  assign go    = (is_rd && !hit) || is_wr;
  assign done  = state == ACCESS && cnt == 3'd0;

`ifdef RAM_LAST_READ_CACHE_EN
  logic              c_valid;
  logic [ADDR_W-1:0] c_tag;
  logic [DATA_W-1:0] c_data;

  assign hit = !rst && state == IDLE && is_rd
               && c_valid && mem.req_addr == c_tag;
  assign mem.rdata = hit ? c_data : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_tag   <= '0;
      c_data  <= '0;
    end else if (done) begin
      if (!wr_q) begin
        c_valid <= 1'b1;
        c_tag   <= sram_addr;
        c_data  <= sram_dq;
      end else if (c_valid && c_tag == sram_addr) begin
        c_data  <= wdata_q;
      end
    end
  end
`else
  assign hit       = 1'b0;
  assign mem.rdata = rdata_q;
`endif

  assign mem.stall = !rst &&
    ((state == IDLE && go) || state == ACCESS);
  assign mem.rdata_valid = rv_q || hit;

  // Write data stays driven through RECOVER for hold after WE rises
  assign sram_dq = dq_oe ? wdata_q : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      wr_q      <= 1'b0;
      dq_oe     <= 1'b0;
      rv_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) rdata_q <= mem.rdata;
          if (go) begin
            state     <= ACCESS;
            cnt       <= 3'(WAIT_CYCLES);
            wr_q      <= is_wr;
            wdata_q   <= mem.req_wdata;
            sram_addr <= mem.req_addr;
            sram_ce_n <= 1'b0;
            sram_oe_n <= is_wr;
            sram_we_n <= !is_wr;
            dq_oe     <= is_wr;
          end
        end
        ACCESS: begin
          if (cnt == 3'd0) begin
            state     <= RECOVER;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (!wr_q) begin
              rdata_q <= sram_dq;
              rv_q    <= 1'b1;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RECOVER: begin
          state     <= IDLE;
          sram_ce_n <= 1'b1;
          dq_oe     <= 1'b0;
          rv_q      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a behavioural async SRAM.
// Build with +define+RAM_LAST_READ_CACHE_EN to cover the cache.
module tb_ram_access_ctrl;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_X   = 2'b11;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  ram_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  ram_access_ctrl #(
    .ADDR_W(16),
    .DATA_W(16),
    .WAIT_CYCLES(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem(bus.slave),
    .sram_addr(sram_addr),
    .sram_dq(sram_dq),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  logic [15:0] sram_mem [0:65535];

  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n)
                   ? sram_mem[sram_addr] : 'z;

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] = sram_dq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_start = 0;
  int oe_cnt = 0;
  int we_cnt = 0;
  int ce_cnt = 0;
  int ovl_cnt = 0;
  int both_cnt = 0;
  logic we_prev = 1'b1;

  logic [15:0] rdq [$];
  wr_t         wrq [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rdata_valid) begin
        if (rdq.size() == 0) begin
          chk("unexpected_rdata_valid", 1, 0);
        end else begin
          logic [15:0] e;
          e = rdq.pop_front();
          chk("rdata", bus.rdata, e);
        end
      end
      if (!we_prev && sram_we_n) begin
        if (wrq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          wr_t w;
          w = wrq.pop_front();
          chk("wr_hold_addr", sram_addr, w.a);
          chk("wr_hold_dq", sram_dq, w.d);
        end
      end
    end
    we_prev = sram_we_n;
    if (!sram_oe_n) oe_cnt++;
    if (!sram_we_n) we_cnt++;
    if (!sram_ce_n) ce_cnt++;
    if (!sram_oe_n && !sram_we_n) ovl_cnt++;
    if (bus.rdata_valid && bus.stall) both_cnt++;
  end

  task automatic access(input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] d, input int exp_stall,
                        input int exp_oe, input int exp_we,
                        input bit chain);
    int n = 0;
    int oe0;
    int we0;
    int ce0;
    @(posedge clk);
    #1;
    if (chain) chk("b2b_spacing", cyc - last_start, 4);
    last_start = cyc;
    oe0 = oe_cnt;
    we0 = we_cnt;
    ce0 = ce_cnt;
    if (op == OP_RD) rdq.push_back(d);
    if (op == OP_WR) wrq.push_back('{a: a, d: d});
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    while (bus.stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", n, exp_stall);
    chk("oe_low_cycles", oe_cnt - oe0, exp_oe);
    chk("we_low_cycles", we_cnt - we0, exp_we);
    if (exp_stall == 0) chk("hit_no_ce", ce_cnt - ce0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got cyc=%0d expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int ce0;
    rst           = 1'b1;
    bus.req_op    = OP_WR;
    bus.req_addr  = 16'h0040;
    bus.req_wdata = 16'hBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_stall", bus.stall, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rvalid", bus.rdata_valid, 0);
    chk("rst_addr", sram_addr, 0);

    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_comb_stall", bus.stall, 1);
    @(negedge clk);
    chk("mid_write_we_n", sram_we_n, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_we_n", sram_we_n, 1);
    chk("midrst_ce_n", sram_ce_n, 1);
    chk("midrst_stall", bus.stall, 0);
    @(negedge clk);
    bus.req_op = OP_NOP;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle_ce_n", sram_ce_n, 1);
    chk("post_rst_stall", bus.stall, 0);

    access(OP_WR, 16'h0040, 16'h1234, 3, 0, 2, 1'b0);
    access(OP_RD, 16'h0040, 16'h1234, 3, 2, 0, 1'b0);

    access(OP_WR, 16'hFFFF, 16'hA5A5, 3, 0, 2, 1'b0);
    access(OP_RD, 16'hFFFF, 16'hA5A5, 3, 2, 0, 1'b1);
    access(OP_WR, 16'h0002, 16'h5A5A, 3, 0, 2, 1'b1);

    @(posedge clk);
    #1;
    ce0 = ce_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.req_op = (i % 2 == 0) ? OP_X : OP_NOP;
      @(negedge clk);
      chk("nop_stall", bus.stall, 0);
    end
    chk("nop_no_ce", ce_cnt - ce0, 0);
    chk("rdata_hold", bus.rdata, 16'hA5A5);

`ifdef RAM_LAST_READ_CACHE_EN
    access(OP_RD, 16'h0040, 16'h1234, 3, 2, 0, 1'b0);
    access(OP_RD, 16'h0040, 16'h1234, 0, 0, 0, 1'b0);
    access(OP_WR, 16'h0040, 16'h00FF, 3, 0, 2, 1'b0);
    access(OP_RD, 16'h0040, 16'h00FF, 0, 0, 0, 1'b0);
`endif

    @(posedge clk);
    #1 bus.req_op = OP_NOP;
    repeat (3) @(negedge clk);
    chk("rd_queue_empty", rdq.size(), 0);
    chk("wr_queue_empty", wrq.size(), 0);
    chk("no_oe_we_overlap", ovl_cnt, 0);
    chk("no_valid_with_stall", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
